// File: rtl/riscy_mem_arbiter.sv
// riscy_mem_arbiter
// Two-to-one arbiter that shares one req/gnt/rvalid memory port between the
// instruction-fetch and data channels of the RISCY core.
//   instr_*     : fetch channel (read only)
//   data_*      : data channel (read/write, byte enables)
//   mem_*       : shared downstream port
//   outstanding_o: granted-but-unanswered transaction count
//   err_o       : sticky, set by an rvalid with nothing outstanding
// Grants are round-robin. A stalled request is locked until granted. An
// in-order ID FIFO steers each response back to its issuing channel.
module riscy_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 instr_req_i,
    input  logic [ADDR_WIDTH-1:0]                instr_addr_i,
    output logic                                 instr_gnt_o,
    output logic                                 instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]                instr_rdata_o,
    input  logic                                 data_req_i,
    input  logic                                 data_we_i,
    input  logic [DATA_WIDTH/8-1:0]              data_be_i,
    input  logic [ADDR_WIDTH-1:0]                data_addr_i,
    input  logic [DATA_WIDTH-1:0]                data_wdata_i,
    output logic                                 data_gnt_o,
    output logic                                 data_rvalid_o,
    output logic [DATA_WIDTH-1:0]                data_rdata_o,
    output logic                                 mem_req_o,
    input  logic                                 mem_gnt_i,
    input  logic                                 mem_rvalid_i,
    output logic                                 mem_we_o,
    output logic [DATA_WIDTH/8-1:0]              mem_be_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);
    localparam logic ChInstr = 1'b0;
    localparam logic ChData  = 1'b1;

    logic                       ptr_q, ptr_d;         // channel with priority on a tie
    logic                       lock_q, lock_d;
    logic                       lock_ch_q, lock_ch_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]            count_q, count_d;
    logic                       err_q, err_d;

    logic any_req;
    logic sel;
    logic push;
    logic pop;
    logic head;

    // Selection and handshake (combinational).
    always_comb begin
        any_req = instr_req_i | data_req_i;
        if (lock_q) begin
            sel = lock_ch_q;
        end else if (instr_req_i && data_req_i) begin
            sel = ptr_q;
        end else begin
            sel = data_req_i ? ChData : ChInstr;
        end
        mem_req_o   = any_req & (count_q < MaxCnt);
        push        = mem_req_o & mem_gnt_i;
        instr_gnt_o = push & (sel == ChInstr);
        data_gnt_o  = push & (sel == ChData);
    end

    // Payload mux; idle payload is zero rather than a stale channel value.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (any_req) begin
            if (sel == ChData) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o   = '1;
                mem_addr_o = instr_addr_i;
            end
        end
    end

    // Response steering. An rvalid with an empty FIFO is dropped; a push in the
    // same cycle does not make it valid, since the earliest response is next cycle.
    always_comb begin
        pop            = mem_rvalid_i & (count_q != '0);
        head           = fifo_q[rd_ptr_q];
        instr_rvalid_o = pop & (head == ChInstr);
        data_rvalid_o  = pop & (head == ChData);
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
        outstanding_o  = count_q;
        err_o          = err_q;
    end

    // Next-state logic.
    always_comb begin
        ptr_d     = ptr_q;
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q | (mem_rvalid_i & (count_q == '0));

        if (push) begin
            ptr_d  = ~sel;
            lock_d = 1'b0;
        end else if (mem_req_o) begin
            lock_d    = 1'b1;
            lock_ch_d = sel;
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= ChData;
            lock_q    <= 1'b0;
            lock_ch_q <= ChInstr;
            fifo_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= sel;
            end
        end
    end

endmodule

// File: tb/tb_riscy_mem_arbiter.sv
module tb_riscy_mem_arbiter;

    localparam int MAX = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic [1:0]  outstanding_o;
    logic        err_o;

    riscy_mem_arbiter #(
        .MAX_OUTSTANDING(MAX),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .instr_req_i   (instr_req_i),
        .instr_addr_i  (instr_addr_i),
        .instr_gnt_o   (instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o (instr_rdata_o),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: queue of issuing channels (0 instr, 1 data) in grant order.
    bit m_q[$];
    bit m_prio;     // channel that wins a tie
    bit m_lock;
    bit m_lock_ch;
    bit m_err;
    bit last_ig, last_dg;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_prio    = 1'b1;
        m_lock    = 1'b0;
        m_lock_ch = 1'b0;
        m_err     = 1'b0;
        last_ig   = 1'b0;
        last_dg   = 1'b0;
    endtask

    // Called just after a negedge with inputs set: check, then advance one clock.
    task automatic cycle();
        bit exp_req, sel, exp_ig, exp_dg, pop, head;
        #1;
        exp_req = (instr_req_i || data_req_i) && (m_q.size() < MAX);
        if (m_lock)                         sel = m_lock_ch;
        else if (instr_req_i && data_req_i) sel = m_prio;
        else                                sel = data_req_i;
        exp_ig = exp_req && mem_gnt_i && !sel;
        exp_dg = exp_req && mem_gnt_i && sel;
        pop    = mem_rvalid_i && (m_q.size() > 0);
        head   = pop ? m_q[0] : 1'b0;

        check_eq("mem_req", mem_req_o, exp_req);
        check_eq("instr_gnt", instr_gnt_o, exp_ig);
        check_eq("data_gnt", data_gnt_o, exp_dg);
        check_eq("instr_rvalid", instr_rvalid_o, pop && !head);
        check_eq("data_rvalid", data_rvalid_o, pop && head);
        check_eq("outstanding", outstanding_o, m_q.size());
        check_eq("err", err_o, m_err);
        if (exp_req) begin
            check_eq("mem_addr", mem_addr_o, sel ? data_addr_i : instr_addr_i);
            check_eq("mem_we", mem_we_o, sel ? data_we_i : 1'b0);
            check_eq("mem_be", mem_be_o, sel ? data_be_i : 4'hF);
            if (sel) check_eq("mem_wdata", mem_wdata_o, data_wdata_i);
        end
        if (pop) begin
            check_eq("instr_rdata", instr_rdata_o, mem_rdata_i);
            check_eq("data_rdata", data_rdata_o, mem_rdata_i);
        end
        last_ig = exp_ig;
        last_dg = exp_dg;

        @(posedge clk_i);
        if (mem_rvalid_i && m_q.size() == 0) m_err = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (exp_ig || exp_dg) begin
            m_q.push_back(sel);
            m_prio = !sel;
            m_lock = 1'b0;
        end else if (exp_req) begin
            m_lock    = 1'b1;
            m_lock_ch = sel;
        end
        @(negedge clk_i);
    endtask

    // Finish pending requests, then return every outstanding response.
    task automatic drain();
        mem_rvalid_i = 1'b0;
        for (int i = 0; i < 40 && (instr_req_i || data_req_i || m_q.size() > 0); i++) begin
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = (m_q.size() > 0);
            mem_rdata_i  = $urandom;
            cycle();
            if (last_ig) instr_req_i = 1'b0;
            if (last_dg) data_req_i = 1'b0;
        end
        check_eq("drain_empty", m_q.size(), 0);
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        check_eq("rst_mem_req", mem_req_o, 1'b0);
        check_eq("rst_outstanding", outstanding_o, 2'd0);
        check_eq("rst_err", err_o, 1'b0);
        check_eq("rst_igrant", instr_gnt_o, 1'b0);
        check_eq("rst_drvalid", data_rvalid_o, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single fetch.
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h80;
        mem_gnt_i    = 1'b1;
        #1;
        check_eq("t1_addr", mem_addr_o, 32'h80);
        check_eq("t1_be", mem_be_o, 4'hF);
        check_eq("t1_gnt", instr_gnt_o, 1'b1);
        cycle();
        instr_req_i  = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0013;
        #1;
        check_eq("t1_rvalid", instr_rvalid_o, 1'b1);
        check_eq("t1_rdata", instr_rdata_o, 32'h13);
        check_eq("t1_out1", outstanding_o, 2'd1);
        cycle();
        mem_rvalid_i = 1'b0;
        #1;
        check_eq("t1_out0", outstanding_o, 2'd0);
        cycle();

        // Both channels continuously requesting: grants alternate from data.
        instr_req_i = 1'b1;
        data_req_i  = 1'b1;
        mem_gnt_i   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr_addr_i = 32'h1000 + 32'(k * 4);
            data_addr_i  = 32'h2000 + 32'(k * 4);
            data_wdata_i = $urandom;
            data_be_i    = 4'(k + 1);
            data_we_i    = k[0];
            mem_rvalid_i = (k > 0);
            mem_rdata_i  = $urandom;
            #1;
            check_eq("rr_dgnt", data_gnt_o, (k % 2) == 0);
            check_eq("rr_ignt", instr_gnt_o, (k % 2) == 1);
            if (k > 0) check_eq("rr_drv", data_rvalid_o, (k % 2) == 1);
            cycle();
        end
        instr_req_i  = 1'b0;
        data_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        #1;
        check_eq("rr_last_irv", instr_rvalid_o, 1'b1);
        cycle();
        mem_rvalid_i = 1'b0;

        // Single data grant moves priority to instr.
        data_req_i = 1'b1;
        mem_gnt_i  = 1'b1;
        cycle();
        data_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        cycle();
        mem_rvalid_i = 1'b0;

        // Lock: stalled data request keeps the port despite instr priority.
        data_req_i   = 1'b1;
        data_addr_i  = 32'h100;
        data_we_i    = 1'b1;
        data_be_i    = 4'h3;
        data_wdata_i = 32'hDEAD;
        instr_addr_i = 32'h200;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) instr_req_i = 1'b1;
            #1;
            check_eq("lk_addr", mem_addr_o, 32'h100);
            check_eq("lk_wdata", mem_wdata_o, 32'hDEAD);
            check_eq("lk_igrant", instr_gnt_o, 1'b0);
            cycle();
        end
        mem_gnt_i = 1'b1;
        #1;
        check_eq("lk_dgrant", data_gnt_o, 1'b1);
        check_eq("lk_be", mem_be_o, 4'h3);
        cycle();
        data_req_i = 1'b0;
        #1;
        check_eq("lk_igrant2", instr_gnt_o, 1'b1);
        check_eq("lk_iaddr", mem_addr_o, 32'h200);
        cycle();
        drain();

        // Full FIFO blocks the request, even alongside an rvalid.
        instr_req_i = 1'b1;
        data_req_i  = 1'b1;
        mem_gnt_i   = 1'b1;
        cycle();
        cycle();
        #1;
        check_eq("full_out", outstanding_o, 2'd2);
        check_eq("full_req", mem_req_o, 1'b0);
        cycle();
        mem_rvalid_i = 1'b1;
        #1;
        check_eq("full_rv_req", mem_req_o, 1'b0);
        cycle();
        mem_rvalid_i = 1'b0;
        #1;
        check_eq("full_reassert", mem_req_o, 1'b1);
        cycle();
        drain();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if (!instr_req_i || last_ig) begin
                instr_req_i  = ($urandom_range(0, 2) != 0);
                instr_addr_i = $urandom;
            end
            if (!data_req_i || last_dg) begin
                data_req_i   = ($urandom_range(0, 2) != 0);
                data_addr_i  = $urandom;
                data_we_i    = $urandom_range(0, 1);
                data_be_i    = $urandom;
                data_wdata_i = $urandom;
            end
            mem_gnt_i    = ($urandom_range(0, 3) != 0);
            mem_rvalid_i = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_i  = $urandom;
            cycle();
        end
        drain();

        // Stray rvalid with empty FIFO.
        mem_rvalid_i = 1'b1;
        #1;
        check_eq("stray_irv", instr_rvalid_o, 1'b0);
        check_eq("stray_drv", data_rvalid_o, 1'b0);
        check_eq("stray_err0", err_o, 1'b0);
        cycle();
        mem_rvalid_i = 1'b0;
        #1;
        check_eq("stray_err1", err_o, 1'b1);
        cycle();
        cycle();

        // Reset with one transaction outstanding.
        instr_req_i = 1'b1;
        mem_gnt_i   = 1'b1;
        cycle();
        instr_req_i = 1'b0;
        mem_gnt_i   = 1'b0;
        #1;
        check_eq("pre_rst_out", outstanding_o, 2'd1);
        rst_ni = 1'b0;
        #1;
        check_eq("arst_out", outstanding_o, 2'd0);
        check_eq("arst_err", err_o, 1'b0);
        check_eq("arst_req", mem_req_o, 1'b0);
        check_eq("arst_ignt", instr_gnt_o, 1'b0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        mem_rvalid_i = 1'b1;
        #1;
        check_eq("post_rst_irv", instr_rvalid_o, 1'b0);
        cycle();
        mem_rvalid_i = 1'b0;
        #1;
        check_eq("post_rst_err", err_o, 1'b1);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
